head_wr_sched: RTL and testbench

HEAD_WR_SCHED -- requirements
Module: head_wr_sched

---
 rtl/hash_table_pkg.sv | 24 ++
 rtl/head_wr_rr_arb.sv | 40 ++++
 rtl/head_wr_sched.sv | 142 ++++++++++++++
 tb/tb_head_wr_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// rtl/hash_table_pkg.sv - shared types and widths for the hash table head-write path
//
// Contents:
//   BUCKET_WIDTH, HEAD_PTR_WIDTH : head table address / pointer widths
//   hws_state_e                  : head write scheduler FSM states
//   wr_req_t                     : one head table write request {addr, ptr, ptr_val}
package hash_table;

  localparam int BUCKET_WIDTH   = 10;
  localparam int HEAD_PTR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_WAIT = 2'd2
  } hws_state_e;

  typedef struct packed {
    logic [BUCKET_WIDTH-1:0]   addr;
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      ptr_val;
  } wr_req_t;

endpackage

// File: rtl/head_wr_rr_arb.sv
// rtl/head_wr_rr_arb.sv - two-input round-robin / fixed-priority grant with last-grant register
//
// Parameters:
//   FIXED_PRIO : 0 = round-robin, 1 = requester 0 always wins
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   en               : arbitration allowed this cycle (scheduler idle, no clear)
//   valid0, valid1   : requester valids
//   ready0, ready1   : combinational grants (at most one high)
module head_wr_rr_arb #(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1
);

  // 1 = requester 1 was granted last; resets to 1 so requester 0 wins first.
  logic last_grant;
  logic winner1;

  assign winner1 = (FIXED_PRIO == 0) && !last_grant;
  assign ready0  = en && valid0 && (!valid1 || !winner1);
  assign ready1  = en && valid1 && (!valid0 ||  winner1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
    end else if (ready0) begin
      last_grant <= 1'b0;
    end else if (ready1) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/head_wr_sched.sv
// rtl/head_wr_sched.sv - head table write scheduler: insert/delete arbitration and table clear sequencing
//
// Optional feature macro: HEAD_WR_SCHED_STATS_EN (adds saturating statistics counters)
// Parameters:
//   FIXED_PRIO : 0 = round-robin, 1 = req0 (insert) always wins
//   CNT_WIDTH  : statistics counter width
// Ports:
//   clk_i, rst_i                          : clock, asynchronous active-high reset
//   reqN_valid_i/ready_o/addr_i/ptr_i/ptr_val_i : write requests, N=0 insert, N=1 delete
//   wr_en_o, wr_addr_o, wr_data_ptr_o, wr_data_ptr_val_o : registered head table write port
//   clear_req_i, clear_busy_o, clear_done_o : clear request / busy / one-cycle done
//   clear_ram_run_o, clear_ram_done_i     : head table clear handshake
//   lookup_block_o                        : blocks new lookups while clearing
//   wr_cnt0_o, wr_cnt1_o, clear_cnt_o     : statistics (macro builds only)
module head_wr_sched
  import hash_table::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req0_valid_i,
  output logic                      req0_ready_o,
  input  logic [BUCKET_WIDTH-1:0]   req0_addr_i,
  input  logic [HEAD_PTR_WIDTH-1:0] req0_ptr_i,
  input  logic                      req0_ptr_val_i,
  input  logic                      req1_valid_i,
  output logic                      req1_ready_o,
  input  logic [BUCKET_WIDTH-1:0]   req1_addr_i,
  input  logic [HEAD_PTR_WIDTH-1:0] req1_ptr_i,
  input  logic                      req1_ptr_val_i,
  output logic                      wr_en_o,
  output logic [BUCKET_WIDTH-1:0]   wr_addr_o,
  output logic [HEAD_PTR_WIDTH-1:0] wr_data_ptr_o,
  output logic                      wr_data_ptr_val_o,
  input  logic                      clear_req_i,
  output logic                      clear_busy_o,
  output logic                      clear_done_o,
  output logic                      clear_ram_run_o,
  input  logic                      clear_ram_done_i,
  output logic                      lookup_block_o
`ifdef HEAD_WR_SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]      wr_cnt0_o,
  output logic [CNT_WIDTH-1:0]      wr_cnt1_o,
  output logic [CNT_WIDTH-1:0]      clear_cnt_o
`endif
);

  hws_state_e state;
  wr_req_t    req0, req1, wr_q;
  logic       arb_en;

  assign req0 = '{addr: req0_addr_i, ptr: req0_ptr_i, ptr_val: req0_ptr_val_i};
  assign req1 = '{addr: req1_addr_i, ptr: req1_ptr_i, ptr_val: req1_ptr_val_i};

  // A clear request wins over any requester in the same cycle; readies also stay
  // low while reset is held so nothing looks accepted during reset.
  assign arb_en = (state == IDLE) && !clear_req_i && !rst_i;

  head_wr_rr_arb #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en     (arb_en),
    .valid0 (req0_valid_i),
    .valid1 (req1_valid_i),
    .ready0 (req0_ready_o),
    .ready1 (req1_ready_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      wr_en_o         <= 1'b0;
      wr_q            <= '0;
      clear_ram_run_o <= 1'b0;
      clear_busy_o    <= 1'b0;
      clear_done_o    <= 1'b0;
      lookup_block_o  <= 1'b0;
    end else begin
      // Write data holds its last value when nothing is accepted.
      wr_en_o <= req0_ready_o || req1_ready_o;
      if (req0_ready_o) begin
        wr_q <= req0;
      end else if (req1_ready_o) begin
        wr_q <= req1;
      end
      clear_ram_run_o <= 1'b0;
      clear_done_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req_i) begin
            state           <= CLR_RUN;
            clear_ram_run_o <= 1'b1;
            clear_busy_o    <= 1'b1;
            lookup_block_o  <= 1'b1;
          end
        end
        CLR_RUN: begin
          state <= CLR_WAIT;
        end
        CLR_WAIT: begin
          if (clear_ram_done_i) begin
            state          <= IDLE;
            clear_busy_o   <= 1'b0;
            lookup_block_o <= 1'b0;
            clear_done_o   <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          clear_busy_o   <= 1'b0;
          lookup_block_o <= 1'b0;
        end
      endcase
    end
  end

  assign wr_addr_o         = wr_q.addr;
  assign wr_data_ptr_o     = wr_q.ptr;
  assign wr_data_ptr_val_o = wr_q.ptr_val;

`ifdef HEAD_WR_SCHED_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt0_o   <= '0;
      wr_cnt1_o   <= '0;
      clear_cnt_o <= '0;
    end else begin
      if (req0_ready_o && (wr_cnt0_o != '1)) wr_cnt0_o <= wr_cnt0_o + 1'b1;
      if (req1_ready_o && (wr_cnt1_o != '1)) wr_cnt1_o <= wr_cnt1_o + 1'b1;
      if ((state == CLR_WAIT) && clear_ram_done_i && (clear_cnt_o != '1)) begin
        clear_cnt_o <= clear_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_head_wr_sched.sv
// tb/tb_head_wr_sched.sv - self-checking bench for head_wr_sched (round-robin and fixed-priority instances)
module tb_head_wr_sched;
  import hash_table::*;

  logic clk, rst;
  logic v0, v1, pv0, pv1, clr, dn;
  logic [9:0]  a0, a1;
  logic [11:0] p0, p1;

  logic [1:0] r0_w, r1_w, wen_w, pv_w, run_w, busy_w, lk_w, done_w;
  logic [1:0][9:0]  waddr_w;
  logic [1:0][11:0] wptr_w;
`ifdef HEAD_WR_SCHED_STATS_EN
  logic [1:0]  cnt0, cnt1, ccnt;
  logic [15:0] fcnt0, fcnt1, fccnt;
`endif

  head_wr_sched #(.FIXED_PRIO(0), .CNT_WIDTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0_w[0]), .req0_addr_i(a0), .req0_ptr_i(p0), .req0_ptr_val_i(pv0),
    .req1_valid_i(v1), .req1_ready_o(r1_w[0]), .req1_addr_i(a1), .req1_ptr_i(p1), .req1_ptr_val_i(pv1),
    .wr_en_o(wen_w[0]), .wr_addr_o(waddr_w[0]), .wr_data_ptr_o(wptr_w[0]), .wr_data_ptr_val_o(pv_w[0]),
    .clear_req_i(clr), .clear_busy_o(busy_w[0]), .clear_done_o(done_w[0]),
    .clear_ram_run_o(run_w[0]), .clear_ram_done_i(dn), .lookup_block_o(lk_w[0])
`ifdef HEAD_WR_SCHED_STATS_EN
    , .wr_cnt0_o(cnt0), .wr_cnt1_o(cnt1), .clear_cnt_o(ccnt)
`endif
  );

  head_wr_sched #(.FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0_w[1]), .req0_addr_i(a0), .req0_ptr_i(p0), .req0_ptr_val_i(pv0),
    .req1_valid_i(v1), .req1_ready_o(r1_w[1]), .req1_addr_i(a1), .req1_ptr_i(p1), .req1_ptr_val_i(pv1),
    .wr_en_o(wen_w[1]), .wr_addr_o(waddr_w[1]), .wr_data_ptr_o(wptr_w[1]), .wr_data_ptr_val_o(pv_w[1]),
    .clear_req_i(clr), .clear_busy_o(busy_w[1]), .clear_done_o(done_w[1]),
    .clear_ram_run_o(run_w[1]), .clear_ram_done_i(dn), .lookup_block_o(lk_w[1])
`ifdef HEAD_WR_SCHED_STATS_EN
    , .wr_cnt0_o(fcnt0), .wr_cnt1_o(fcnt1), .clear_cnt_o(fccnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Reference model: clear phase as plain integer (0 idle, 1 run, 2 wait),
  // per-instance last winner and pending write.
  int          m_phase;
  int          m_last [2];
  logic        m_wen  [2];
  logic [9:0]  m_addr [2];
  logic [11:0] m_ptr  [2];
  logic        m_pv   [2];
  logic        m_done;
  int          m_c0, m_c1, m_cc;
  int          s_g0;
  logic        s_r0, s_r1, s_busy, s_run, s_done, s_lk, s_wen;
  logic [9:0]  s_waddr;

  function automatic void model_reset();
    m_phase = 0; m_done = 1'b0; m_c0 = 0; m_c1 = 0; m_cc = 0;
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1; m_wen[k] = 1'b0; m_addr[k] = '0; m_ptr[k] = '0; m_pv[k] = 1'b0;
    end
  endfunction

  function automatic int grant(input int k, input logic gv0, input logic gv1, input logic gclr);
    if (m_phase != 0 || gclr) return -1;
    if (gv0 && gv1) return (k == 1) ? 0 : ((m_last[k] == 1) ? 0 : 1);
    if (gv0) return 0;
    if (gv1) return 1;
    return -1;
  endfunction

  function automatic int sat(input int n);
    return (n >= 3) ? 3 : n + 1;
  endfunction

  task automatic step(input logic iv0, input logic iv1, input logic [9:0] ia0, input logic [9:0] ia1,
                      input logic iclr, input logic idn);
    int g [2];
    v0 = iv0; v1 = iv1; a0 = ia0; a1 = ia1; clr = iclr; dn = idn;
    p0 = {2'b00, ia0} + 12'd3; p1 = {2'b01, ia1}; pv0 = ia0[0]; pv1 = ~ia1[1];
    #3;
    for (int k = 0; k < 2; k++) begin
      g[k] = grant(k, iv0, iv1, iclr);
      chk($sformatf("ready0[%0d]", k), r0_w[k], g[k] == 0);
      chk($sformatf("ready1[%0d]", k), r1_w[k], g[k] == 1);
      chk($sformatf("wr_en[%0d]", k), wen_w[k], m_wen[k]);
      chk($sformatf("wr_addr[%0d]", k), waddr_w[k], m_addr[k]);
      chk($sformatf("wr_ptr[%0d]", k), wptr_w[k], m_ptr[k]);
      chk($sformatf("wr_ptr_val[%0d]", k), pv_w[k], m_pv[k]);
      chk($sformatf("run[%0d]", k), run_w[k], m_phase == 1);
      chk($sformatf("busy[%0d]", k), busy_w[k], m_phase != 0);
      chk($sformatf("lookup_block[%0d]", k), lk_w[k], m_phase != 0);
      chk($sformatf("done[%0d]", k), done_w[k], m_done);
    end
`ifdef HEAD_WR_SCHED_STATS_EN
    chk("wr_cnt0", cnt0, m_c0);
    chk("wr_cnt1", cnt1, m_c1);
    chk("clear_cnt", ccnt, m_cc);
`endif
    s_g0 = g[0]; s_r0 = r0_w[0]; s_r1 = r1_w[0]; s_busy = busy_w[0]; s_run = run_w[0];
    s_done = done_w[0]; s_lk = lk_w[0]; s_wen = wen_w[0]; s_waddr = waddr_w[0];
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      if (g[k] == 0) begin
        m_wen[k] = 1'b1; m_addr[k] = ia0; m_ptr[k] = {2'b00, ia0} + 12'd3; m_pv[k] = ia0[0]; m_last[k] = 0;
      end else if (g[k] == 1) begin
        m_wen[k] = 1'b1; m_addr[k] = ia1; m_ptr[k] = {2'b01, ia1}; m_pv[k] = ~ia1[1]; m_last[k] = 1;
      end else begin
        m_wen[k] = 1'b0;
      end
    end
    if (g[0] == 0) m_c0 = sat(m_c0);
    if (g[0] == 1) m_c1 = sat(m_c1);
    m_done = 1'b0;
    if (m_phase == 0) begin
      if (iclr) m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (idn) begin
      m_phase = 0; m_done = 1'b1; m_cc = sat(m_cc);
    end
  endtask

  typedef struct packed {
    logic v0, v1; logic [9:0] a0, a1; logic clr, dn;
    logic r0, r1, wen; logic [9:0] waddr; logic busy, run, done;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nbusy, nlk, nrun, ndone;
    logic hv0, hv1;
    logic [9:0] ha0, ha1;
    //             v0 v1 a0     a1     clr dn r0 r1 wen waddr  busy run done
    tbl[0]  = '{1'b1,1'b0,10'h05,10'h00,1'b0,1'b0,1'b1,1'b0,1'b0,10'h00,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,10'h06,10'h00,1'b0,1'b0,1'b1,1'b0,1'b1,10'h05,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,10'h07,10'h00,1'b0,1'b0,1'b1,1'b0,1'b1,10'h06,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,10'h00,10'h00,1'b0,1'b0,1'b0,1'b0,1'b1,10'h07,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,10'h00,10'h00,1'b0,1'b0,1'b0,1'b0,1'b0,10'h07,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,10'h00,10'h11,1'b0,1'b0,1'b0,1'b1,1'b0,10'h07,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b1,10'h20,10'h21,1'b0,1'b0,1'b1,1'b0,1'b1,10'h11,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b1,10'h20,10'h21,1'b0,1'b0,1'b0,1'b1,1'b1,10'h20,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b1,10'h20,10'h21,1'b0,1'b0,1'b1,1'b0,1'b1,10'h21,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b1,10'h20,10'h21,1'b0,1'b0,1'b0,1'b1,1'b1,10'h20,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,10'h00,10'h00,1'b0,1'b0,1'b0,1'b0,1'b1,10'h21,1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,10'h00,10'h33,1'b1,1'b0,1'b0,1'b0,1'b0,10'h21,1'b0,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b1,10'h00,10'h33,1'b0,1'b1,1'b0,1'b0,1'b0,10'h21,1'b1,1'b1,1'b0};
    tbl[13] = '{1'b0,1'b1,10'h00,10'h33,1'b1,1'b0,1'b0,1'b0,1'b0,10'h21,1'b1,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b1,10'h00,10'h33,1'b0,1'b1,1'b0,1'b0,1'b0,10'h21,1'b1,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b1,10'h00,10'h33,1'b0,1'b0,1'b0,1'b1,1'b0,10'h21,1'b0,1'b0,1'b1};
    tbl[16] = '{1'b0,1'b0,10'h00,10'h00,1'b0,1'b0,1'b0,1'b0,1'b1,10'h33,1'b0,1'b0,1'b0};

    v0 = 0; v1 = 0; a0 = 0; a1 = 0; p0 = 0; p1 = 0; pv0 = 0; pv1 = 0; clr = 0; dn = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed table: single requester, contention, clear blocking a request.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].clr, tbl[i].dn);
      chk($sformatf("tbl%0d.ready0", i), s_r0, tbl[i].r0);
      chk($sformatf("tbl%0d.ready1", i), s_r1, tbl[i].r1);
      chk($sformatf("tbl%0d.wr_en", i), s_wen, tbl[i].wen);
      chk($sformatf("tbl%0d.wr_addr", i), s_waddr, tbl[i].waddr);
      chk($sformatf("tbl%0d.busy", i), s_busy, tbl[i].busy);
      chk($sformatf("tbl%0d.run", i), s_run, tbl[i].run);
      chk($sformatf("tbl%0d.done", i), s_done, tbl[i].done);
    end

    // Long clear: done returned 10 cycles after run, extra clear request mid-way.
    nbusy = 0; nlk = 0; nrun = 0; ndone = 0;
    step(1'b0, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 1'b0, 10'h0, 10'h0, i == 5, i == 11);
      nbusy += int'(s_busy); nlk += int'(s_lk); nrun += int'(s_run); ndone += int'(s_done);
    end
    chk("long_clear.busy_cycles", nbusy, 11);
    chk("long_clear.lookup_cycles", nlk, 11);
    chk("long_clear.run_pulses", nrun, 1);
    chk("long_clear.done_pulses", ndone, 1);

    // Reset in CLR_WAIT with req0 held.
    step(1'b1, 1'b0, 10'h3A, 10'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 10'h3A, 10'h0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("rst.wr_en", wen_w, 2'b00);
    chk("rst.run", run_w, 2'b00);
    chk("rst.busy", busy_w, 2'b00);
    chk("rst.lookup_block", lk_w, 2'b00);
    chk("rst.done", done_w, 2'b00);
    chk("rst.ready0", r0_w, 2'b00);
    chk("rst.wr_addr", waddr_w[0], 10'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 10'h3A, 10'h0, 1'b0, 1'b0);
    chk("post_rst.ready0", s_r0, 1'b1);

    // Four more req0 writes (five total since reset), then one clear.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'h40 + 10'(i), 10'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
`ifdef HEAD_WR_SCHED_STATS_EN
    chk("stats.wr_cnt0_sat", cnt0, 2'd3);
    chk("stats.clear_cnt", ccnt, 2'd1);
`endif

    // Randomized traffic; requesters hold valid/data until accepted.
    hv0 = 1'b0; hv1 = 1'b0; ha0 = '0; ha1 = '0;
    for (int i = 0; i < 500; i++) begin
      if (!hv0) begin hv0 = ($urandom_range(0, 2) != 0); ha0 = 10'($urandom); end
      if (!hv1) begin hv1 = ($urandom_range(0, 2) != 0); ha1 = 10'($urandom); end
      step(hv0, hv1, ha0, ha1, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      if (s_g0 == 0) hv0 = 1'b0;
      if (s_g0 == 1) hv1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
